// File: rtl/mx_pkg.sv
// mx_pkg: shared MX constants, E8M0 scale encoding and default element field layout.
package mx_pkg;
  localparam int ELEM_EXP_W = 4;
  localparam int ELEM_MAN_W = 3;
  localparam int ELEM_BIAS  = 7;
  localparam int SH_W       = 11;
  localparam int E8M0_BIAS  = 127;
  localparam logic [7:0] E8M0_NAN = 8'hFF;
  typedef struct packed {
    logic                  sign;
    logic [ELEM_EXP_W-1:0] exp;
    logic [ELEM_MAN_W-1:0] man;
  } elem_t;
endpackage

// File: rtl/shift_sat_int.sv
// shift_sat_int: bidirectional shift of a significand, saturation to a signed range, and negation.
module shift_sat_int
  import mx_pkg::*;
#(
  parameter int MAN_W   = ELEM_MAN_W,
  parameter int WIDTH_O = 16
) (
  input  logic                   sign_i,
  input  logic [MAN_W:0]         m_i,
  input  logic signed [SH_W-1:0] shift_i,
  input  logic                   nan_i,
  output logic [WIDTH_O-1:0]     int_o,
  output logic                   sat_o
);
  // Wide enough to hold m_i shifted left by up to WIDTH_O without losing bits
  localparam int XW = WIDTH_O + MAN_W + 2;
  localparam logic [XW-1:0] LIM_N = XW'(1) << (WIDTH_O - 1);
  localparam logic [XW-1:0] LIM_P = LIM_N - XW'(1);
  logic [XW-1:0] mag_x;
  logic big, ovf;
  logic [WIDTH_O-1:0] mag;
  always_comb begin
    big   = !shift_i[SH_W-1] && (shift_i > SH_W'(WIDTH_O));
    mag_x = shift_i[SH_W-1] ? XW'(m_i) >> (-shift_i) : XW'(m_i) << shift_i;
    ovf   = |m_i && (big || mag_x > (sign_i ? LIM_N : LIM_P));
    mag   = mag_x[WIDTH_O-1:0];
    sat_o = !nan_i && ovf;
    int_o = nan_i ? '0 :
            ovf   ? (sign_i ? LIM_N[WIDTH_O-1:0] : LIM_P[WIDTH_O-1:0]) :
            sign_i ? -mag : mag;
  end
endmodule

// File: rtl/mx_elem_to_int.sv
// mx_elem_to_int: expands an MX element with its E8M0 block scale into a saturated signed
// fixed-point integer through a 2-stage valid/ready pipeline (decode, then shift/saturate).
module mx_elem_to_int
  import mx_pkg::*;
#(
  parameter int EXP_W   = ELEM_EXP_W,
  parameter int MAN_W   = ELEM_MAN_W,
  parameter int BIAS    = ELEM_BIAS,
  parameter int WIDTH_O = 16,
  parameter int FRAC_W  = 0
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [EXP_W+MAN_W:0]   i_elem,
  input  logic [7:0]             i_scale,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [WIDTH_O-1:0]     o_int,
  output logic                   o_sat,
  output logic                   o_nan
);
  logic s1_valid_q, s1_sign_q, s1_nan_q, s2_valid_q, o_sat_q, o_nan_q;
  logic [MAN_W:0] s1_m_q, s1_m_d;
  logic signed [SH_W-1:0] s1_shift_q, s1_shift_d;
  logic [EXP_W-1:0] exp_w;
  logic [WIDTH_O-1:0] o_int_q, int_d;
  logic sat_d, s2_adv;
  always_comb begin
    exp_w      = i_elem[EXP_W+MAN_W-1:MAN_W];
    s1_m_d     = {|exp_w, i_elem[MAN_W-1:0]};
    // Subnormals share the exponent of the smallest normal
    s1_shift_d = SH_W'((exp_w == '0) ? EXP_W'(1) : exp_w) + SH_W'(i_scale)
               - SH_W'(BIAS + MAN_W + E8M0_BIAS - FRAC_W);
    s2_adv     = !s2_valid_q || i_ready;
    o_ready    = !s1_valid_q || s2_adv;
  end
  shift_sat_int #(.MAN_W(MAN_W), .WIDTH_O(WIDTH_O)) u_shift_sat (
    .sign_i (s1_sign_q),
    .m_i    (s1_m_q),
    .shift_i(s1_shift_q),
    .nan_i  (s1_nan_q),
    .int_o  (int_d),
    .sat_o  (sat_d)
  );
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_m_q     <= '0;
      s1_shift_q <= '0;
      s1_nan_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      o_int_q    <= '0;
      o_sat_q    <= 1'b0;
      o_nan_q    <= 1'b0;
    end else begin
      if (o_ready) begin
        s1_valid_q <= i_valid;
        if (i_valid) begin
          s1_sign_q  <= i_elem[EXP_W+MAN_W];
          s1_m_q     <= s1_m_d;
          s1_shift_q <= s1_shift_d;
          s1_nan_q   <= (i_scale == E8M0_NAN);
        end
      end
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          o_int_q <= int_d;
          o_sat_q <= sat_d;
          o_nan_q <= s1_nan_q;
        end
      end
    end
  end
  assign o_valid = s2_valid_q;
  assign o_int   = o_int_q;
  assign o_sat   = o_sat_q;
  assign o_nan   = o_nan_q;
endmodule

// File: tb/tb_mx_elem_to_int.sv
// tb_mx_elem_to_int: scoreboard bench for mx_elem_to_int at default parameters.
module tb_mx_elem_to_int;
  import mx_pkg::*;
  logic clk = 1'b0, i_rst_n, i_valid, o_ready, o_valid, i_ready, o_sat, o_nan;
  logic [7:0] i_elem, i_scale;
  logic [15:0] o_int;
  int total = 0, bad = 0;
  typedef struct { int v; bit sat; bit nan; } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  mx_elem_to_int dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_elem(i_elem), .i_scale(i_scale), .o_valid(o_valid), .i_ready(i_ready),
    .o_int(o_int), .o_sat(o_sat), .o_nan(o_nan)
  );

  // Value = (-1)^s * M * 2^(e_eff - 10 + scale - 127), truncated toward zero, then clamped
  function automatic exp_t model(input logic [7:0] e, input logic [7:0] s);
    exp_t r;
    elem_t f;
    int m, sh;
    longint mag, v;
    f = e;
    m = (f.exp != 0 ? 8 : 0) + int'(f.man);
    sh = (f.exp == 0 ? 1 : int'(f.exp)) - 10 + int'(s) - 127;
    if (sh > 40) mag = (m != 0) ? (64'sd1 <<< 40) : 0;
    else if (sh >= 0) mag = longint'(m) <<< sh;
    else if (-sh > 8) mag = 0;
    else mag = longint'(m) >>> (-sh);
    v = f.sign ? -mag : mag;
    r.nan = (s == 8'hFF);
    r.sat = !r.nan && (v > 32767 || v < -32768);
    r.v = r.nan ? 0 : v > 32767 ? 32767 : v < -32768 ? -32768 : int'(v);
    return r;
  endfunction

  task automatic send(input logic [7:0] e, input logic [7:0] s);
    @(posedge clk); #1;
    i_valid = 1'b1; i_elem = e; i_scale = s;
    @(negedge clk);
    for (int k = 0; k < 20 && !o_ready; k++) @(negedge clk);
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic test_reset;
    i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_elem = '0; i_scale = '0;
    repeat (3) @(negedge clk);
    total++;
    if (o_valid !== 1'b0 || o_int !== 16'd0 || o_sat !== 1'b0 || o_nan !== 1'b0) begin
      bad++; $display("FAIL reset_outputs: got v=%b int=%0d sat=%b nan=%b want all 0", o_valid, o_int, o_sat, o_nan);
    end
    i_rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      bad++; $display("FAIL reset_release: got ready=%b valid=%b want 1 0", o_ready, o_valid);
    end
  endtask

  task automatic test_directed;
    logic [7:0] ve[17] = '{8'h38, 8'h44, 8'hC4, 8'h01, 8'h01, 8'h77, 8'hF7, 8'h38, 8'hF7,
                          8'h3C, 8'hBC, 8'h38, 8'hB8, 8'h80, 8'h7F, 8'h38, 8'h38};
    logic [7:0] vs[17] = '{8'd127, 8'd130, 8'd130, 8'd136, 8'd135, 8'd135, 8'd135, 8'hFF, 8'hFF,
                          8'd127, 8'd127, 8'd142, 8'd142, 8'd127, 8'd254, 8'd0, 8'd137};
    int ev[17] = '{1, 24, -24, 1, 0, 32767, -32768, 0, 0, 1, -1, 32767, -32768, 0, 32767, 0, 1024};
    bit es[17] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0};
    bit en[17] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    exp_t x;
    int lat;
    i_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      q.push_back('{ev[i], es[i], en[i]});
      send(ve[i], vs[i]);
      lat = 1;
      @(negedge clk);
      while (!o_valid && lat < 10) begin @(negedge clk); lat++; end
      x = q.pop_front();
      if (i == 0) begin
        total++;
        if (lat !== 2) begin bad++; $display("FAIL latency: got %0d want 2", lat); end
      end
      total++;
      if (o_valid !== 1'b1 || int'($signed(o_int)) !== x.v || o_sat !== x.sat || o_nan !== x.nan) begin
        bad++;
        $display("FAIL directed[%0d] elem=%h scale=%0d: got v=%b int=%0d sat=%b nan=%b want int=%0d sat=%b nan=%b",
                 i, ve[i], vs[i], o_valid, $signed(o_int), o_sat, o_nan, x.v, x.sat, x.nan);
      end
    end
  endtask

  task automatic test_back_to_back;
    exp_t x;
    i_ready = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk); #1;
      i_valid = (k < 10);
      i_elem = 8'($urandom);
      i_scale = 8'($urandom_range(120, 140));
      @(negedge clk);
      total++;
      if (o_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d]: got %b want 1", k, o_ready); end
      if (k >= 2 && k < 12) begin
        total++;
        if (o_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid[%0d]: got %b want 1", k, o_valid); end
      end
      if (o_valid && q.size() > 0) begin
        x = q.pop_front();
        total++;
        if (int'($signed(o_int)) !== x.v || o_sat !== x.sat || o_nan !== x.nan) begin
          bad++; $display("FAIL b2b_data[%0d]: got int=%0d sat=%b nan=%b want %0d %b %b", k, $signed(o_int), o_sat, o_nan, x.v, x.sat, x.nan);
        end
      end
      if (i_valid && o_ready) q.push_back(model(i_elem, i_scale));
    end
    i_valid = 1'b0;
    total++;
    if (q.size() !== 0) begin bad++; $display("FAIL b2b_count: got %0d left want 0", q.size()); end
    q.delete();
  endtask

  task automatic test_random_stream;
    int sent = 0, cyc = 0;
    bit did_rst = 0, hold = 0, pend = 0;
    logic [15:0] h_int;
    logic h_sat, h_nan;
    exp_t x;
    while (sent < 200 && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
      if (!did_rst && sent >= 100) begin
        did_rst = 1; i_rst_n = 1'b0; i_valid = 1'b0; q.delete(); hold = 0; pend = 0;
        @(negedge clk);
        total++;
        if (o_valid !== 1'b0 || o_int !== 16'd0) begin
          bad++; $display("FAIL mid_reset: got valid=%b int=%0d want 0 0", o_valid, o_int);
        end
        i_rst_n = 1'b1;
        continue;
      end
      if (!pend) begin
        i_valid = ($urandom_range(0, 9) < 7);
        i_elem = 8'($urandom);
        i_scale = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(115, 150));
      end
      i_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      if (hold) begin
        total++;
        if (o_valid !== 1'b1 || o_int !== h_int || o_sat !== h_sat || o_nan !== h_nan) begin
          bad++; $display("FAIL stall_stable: got v=%b int=%h sat=%b nan=%b want 1 %h %b %b", o_valid, o_int, o_sat, o_nan, h_int, h_sat, h_nan);
        end
      end
      if (o_valid && i_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL stream_extra: got output %0d want none", $signed(o_int));
        end else begin
          x = q.pop_front();
          if (int'($signed(o_int)) !== x.v || o_sat !== x.sat || o_nan !== x.nan) begin
            bad++; $display("FAIL stream_data: got int=%0d sat=%b nan=%b want %0d %b %b", $signed(o_int), o_sat, o_nan, x.v, x.sat, x.nan);
          end
        end
      end
      hold = o_valid && !i_ready;
      h_int = o_int; h_sat = o_sat; h_nan = o_nan;
      pend = i_valid && !o_ready;
      if (i_valid && o_ready) begin q.push_back(model(i_elem, i_scale)); sent++; end
    end
    @(posedge clk); #1;
    i_valid = 1'b0; i_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (o_valid) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL drain_extra: got output %0d want none", $signed(o_int));
        end else begin
          x = q.pop_front();
          if (int'($signed(o_int)) !== x.v || o_sat !== x.sat || o_nan !== x.nan) begin
            bad++; $display("FAIL drain_data: got int=%0d sat=%b nan=%b want %0d %b %b", $signed(o_int), o_sat, o_nan, x.v, x.sat, x.nan);
          end
        end
      end
    end
    total++;
    if (q.size() !== 0 || sent < 200) begin
      bad++; $display("FAIL stream_complete: got left=%0d sent=%0d want 0 200", q.size(), sent);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
